// File: rtl/bomb_pkg.sv
// bomb_pkg: shared types and helpers for the bomb scheduler.
//   - slot state enum, tile / pending-request structs
//   - map geometry (HMAXTILE, VMAXTILE, MAPW)
//   - tile_idx / blast_mask / map_bit helpers used for map bitmaps
package bomb_pkg;
  localparam int HMAXTILE = 9;
  localparam int VMAXTILE = 5;
  localparam int MAPW     = (HMAXTILE + 1) * (VMAXTILE + 1);

  typedef enum logic [1:0] {IDLE = 2'd0, ARMED = 2'd1, BLAST = 2'd2} slot_st_e;

  typedef struct packed {
    logic [3:0] h;
    logic [3:0] v;
  } tile_t;

  typedef struct packed {
    logic  vld;
    tile_t t;
  } pend_t;

  function automatic int tile_idx(input logic [3:0] h, input logic [3:0] v);
    return (HMAXTILE + 1) * int'(v) + int'(h);
  endfunction

  function automatic logic in_map(input logic [3:0] h, input logic [3:0] v);
    return (int'(h) <= HMAXTILE) && (int'(v) <= VMAXTILE);
  endfunction

  // Radius-1 cross; edge neighbours are dropped rather than wrapped.
  function automatic logic [MAPW-1:0] blast_mask(input logic [3:0] h, input logic [3:0] v);
    logic [MAPW-1:0] m;
    int c;
    m = '0;
    c = tile_idx(h, v);
    if (in_map(h, v)) begin
      m |= MAPW'(1) << c;
      if (int'(h) > 0)        m |= MAPW'(1) << (c - 1);
      if (int'(h) < HMAXTILE) m |= MAPW'(1) << (c + 1);
      if (int'(v) > 0)        m |= MAPW'(1) << (c - HMAXTILE - 1);
      if (int'(v) < VMAXTILE) m |= MAPW'(1) << (c + HMAXTILE + 1);
    end
    return m;
  endfunction

  // Bit of a map at a tile; off-map tiles read as 0 instead of aliasing.
  function automatic logic map_bit(input logic [MAPW-1:0] m, input tile_t t);
    logic [MAPW-1:0] s;
    s = m >> tile_idx(t.h, t.v);
    return in_map(t.h, t.v) & s[0];
  endfunction
endpackage

// File: rtl/bomb_slot.sv
// bomb_slot: one pool entry. IDLE -> ARMED on arm (fuse), ARMED -> BLAST on
// fuse expiry or chain, BLAST -> IDLE when the blast counter runs out.
//   clk, rst     : clock, synchronous active-high reset
//   arm, armTile : grant this slot and the tile it occupies
//   chain        : own tile lies inside an active blast
//   state, tile  : current slot state and tile
module bomb_slot
  import bomb_pkg::*;
#(
  parameter int          FUSEW        = 27,
  parameter int unsigned FUSE_CYCLES  = 2**27 - 1,
  parameter int unsigned BLAST_CYCLES = 2**25
) (
  input  logic     clk,
  input  logic     rst,
  input  logic     arm,
  input  tile_t    armTile,
  input  logic     chain,
  output slot_st_e state,
  output tile_t    tile
);
  // Counters load N-1 so each phase lasts exactly N cycles.
  localparam logic [FUSEW-1:0] FUSE_LD  = FUSEW'(FUSE_CYCLES - 1);
  localparam logic [FUSEW-1:0] BLAST_LD = FUSEW'(BLAST_CYCLES - 1);

  slot_st_e         st_q, st_d;
  logic [FUSEW-1:0] cnt_q, cnt_d;
  tile_t            tile_q, tile_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      st_q   <= IDLE;
      cnt_q  <= '0;
      tile_q <= '0;
    end else begin
      st_q   <= st_d;
      cnt_q  <= cnt_d;
      tile_q <= tile_d;
    end
  end

  always_comb begin
    st_d   = st_q;
    cnt_d  = cnt_q;
    tile_d = tile_q;
    case (st_q)
      IDLE: if (arm) begin
        st_d   = ARMED;
        cnt_d  = FUSE_LD;
        tile_d = armTile;
      end
      ARMED: if (chain || cnt_q == '0) begin
        st_d  = BLAST;
        cnt_d = BLAST_LD;
      end else begin
        cnt_d = cnt_q - 1'b1;
      end
      BLAST: if (cnt_q == '0) st_d = IDLE;
             else             cnt_d = cnt_q - 1'b1;
      default: st_d = IDLE;
    endcase
  end

  assign state = st_q;
  assign tile  = tile_q;
endmodule

// File: rtl/bomb_scheduler.sv
// bomb_scheduler: captures placement pulses from two players, arbitrates them
// round-robin onto NSLOT bomb slots, and publishes occupied/blast bitmaps.
//   clk, rst                : clock, synchronous active-high reset
//   place0/1, p0h/p0v/p1h/p1v : placement pulse and player tile
//   accept0/1, reject0/1    : one-cycle registered grant outcome pulses
//   bombMap, blastMap       : armed-bomb and active-blast tile bitmaps
//   hit0/1                  : registered "player tile is in blastMap"
//   freeSlots               : number of IDLE slots
module bomb_scheduler
  import bomb_pkg::*;
#(
  parameter  int          HMAXTILE     = bomb_pkg::HMAXTILE,
  parameter  int          VMAXTILE     = bomb_pkg::VMAXTILE,
  parameter  int          NSLOT        = 8,
  parameter  int          FUSEW        = 27,
  parameter  int unsigned FUSE_CYCLES  = 2**27 - 1,
  parameter  int unsigned BLAST_CYCLES = 2**25,
  localparam int          MW           = (HMAXTILE + 1) * (VMAXTILE + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          place0,
  input  logic          place1,
  input  logic [3:0]    p0h,
  input  logic [3:0]    p0v,
  input  logic [3:0]    p1h,
  input  logic [3:0]    p1v,
  output logic          accept0,
  output logic          accept1,
  output logic          reject0,
  output logic          reject1,
  output logic [MW-1:0] bombMap,
  output logic [MW-1:0] blastMap,
  output logic          hit0,
  output logic          hit1,
  output logic [3:0]    freeSlots
);
  slot_st_e [NSLOT-1:0] st;
  tile_t    [NSLOT-1:0] tl;
  logic     [NSLOT-1:0] arm, chain;

  pend_t [1:0] pend_q, pend_d;
  tile_t [1:0] ptile;
  logic  [1:0] place, acc_q, acc_d, rej_q, rej_d, hit_q, hit_d;
  logic        rr_q, rr_d;

  logic [MW-1:0] bomb_map, blast_map;
  logic [3:0]    free_cnt;
  logic          gnt, sel, ok;
  tile_t         gtile;

  assign place    = {place1, place0};
  assign ptile[0] = tile_t'({p0h, p0v});
  assign ptile[1] = tile_t'({p1h, p1v});

  for (genvar g = 0; g < NSLOT; g++) begin : g_slot
    bomb_slot #(
      .FUSEW       (FUSEW),
      .FUSE_CYCLES (FUSE_CYCLES),
      .BLAST_CYCLES(BLAST_CYCLES)
    ) u_slot (
      .clk    (clk),
      .rst    (rst),
      .arm    (arm[g]),
      .armTile(gtile),
      .chain  (chain[g]),
      .state  (st[g]),
      .tile   (tl[g])
    );
  end

  // Maps and free count come straight from slot registers.
  always_comb begin
    bomb_map  = '0;
    blast_map = '0;
    free_cnt  = '0;
    for (int i = 0; i < NSLOT; i++) begin
      if (st[i] == ARMED) bomb_map  |= MW'(1) << tile_idx(tl[i].h, tl[i].v);
      if (st[i] == BLAST) blast_map |= blast_mask(tl[i].h, tl[i].v);
      if (st[i] == IDLE)  free_cnt   = free_cnt + 4'd1;
    end
  end

  // Only meaningful while ARMED; the slot ignores it otherwise.
  always_comb begin
    chain = '0;
    for (int i = 0; i < NSLOT; i++) chain[i] = map_bit(blast_map, tl[i]);
  end

  // Arbiter: rr only breaks ties; a lone request is always served.
  always_comb begin
    gnt   = pend_q[0].vld | pend_q[1].vld;
    sel   = (pend_q[0].vld && pend_q[1].vld) ? rr_q : pend_q[1].vld;
    gtile = pend_q[sel].t;
    ok    = gnt && (free_cnt != '0) && !map_bit(bomb_map, gtile);
    rr_d  = gnt ? ~sel : rr_q;
  end

  // Lowest-index IDLE slot takes the accepted request.
  always_comb begin
    logic found;
    arm   = '0;
    found = 1'b0;
    for (int i = 0; i < NSLOT; i++) begin
      if (ok && !found && st[i] == IDLE) begin
        arm[i] = 1'b1;
        found  = 1'b1;
      end
    end
  end

  always_comb begin
    pend_d = pend_q;
    acc_d  = '0;
    rej_d  = '0;
    for (int p = 0; p < 2; p++) begin
      if (gnt && sel == p[0]) begin
        pend_d[p].vld = 1'b0;
        acc_d[p]      = ok;
        rej_d[p]      = !ok;
      end
      // A player can be mid-grant and re-placing at once; both pulses may fire.
      if (place[p]) begin
        if (pend_q[p].vld) rej_d[p] = 1'b1;
        else               pend_d[p] = '{vld: 1'b1, t: ptile[p]};
      end
      hit_d[p] = map_bit(blast_map, ptile[p]);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pend_q <= '0;
      acc_q  <= '0;
      rej_q  <= '0;
      hit_q  <= '0;
      rr_q   <= 1'b0;
    end else begin
      pend_q <= pend_d;
      acc_q  <= acc_d;
      rej_q  <= rej_d;
      hit_q  <= hit_d;
      rr_q   <= rr_d;
    end
  end

  assign accept0   = acc_q[0];
  assign accept1   = acc_q[1];
  assign reject0   = rej_q[0];
  assign reject1   = rej_q[1];
  assign hit0      = hit_q[0];
  assign hit1      = hit_q[1];
  assign bombMap   = bomb_map;
  assign blastMap  = blast_map;
  assign freeSlots = free_cnt;
endmodule

// File: tb/tb_bomb_scheduler.sv
module tb_bomb_scheduler;
  localparam int MW = 60;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          place0 = 1'b0, place1 = 1'b0;
  logic [3:0]    p0h = '0, p0v = '0, p1h = '0, p1v = '0;
  logic          accept0, accept1, reject0, reject1, hit0, hit1;
  logic [MW-1:0] bombMap, blastMap;
  logic [3:0]    freeSlots;

  int n_chk = 0;
  int n_err = 0;

  bomb_scheduler #(
    .NSLOT(2), .FUSEW(4), .FUSE_CYCLES(8), .BLAST_CYCLES(4)
  ) dut (
    .clk(clk), .rst(rst),
    .place0(place0), .place1(place1),
    .p0h(p0h), .p0v(p0v), .p1h(p1h), .p1v(p1v),
    .accept0(accept0), .accept1(accept1),
    .reject0(reject0), .reject1(reject1),
    .bombMap(bombMap), .blastMap(blastMap),
    .hit0(hit0), .hit1(hit1), .freeSlots(freeSlots)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Bitmap from up to 8 tile indices; -1 entries are skipped.
  function automatic logic [63:0] mk(input int a, b, c, d, e, f, g, h);
    int l[8];
    logic [63:0] m;
    l = '{a, b, c, d, e, f, g, h};
    m = '0;
    foreach (l[i]) if (l[i] >= 0) m[l[i]] = 1'b1;
    return m;
  endfunction

  task automatic reset_dut();
    rst = 1'b1; place0 = 1'b0; place1 = 1'b0;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    // reset state
    reset_dut();
    chk("rst_bomb",  64'(bombMap), 64'd0);
    chk("rst_blast", 64'(blastMap), 64'd0);
    chk("rst_free",  64'(freeSlots), 64'd2);
    chk("rst_pulse", 64'({accept0, accept1, reject0, reject1, hit0, hit1}), 64'd0);

    // 1: single bomb at (3,2), full fuse/blast/release
    place0 = 1'b1; p0h = 4'd3; p0v = 4'd2;
    tick();
    place0 = 1'b0;
    chk("s1_acc_early", 64'(accept0), 64'd0);
    tick();
    for (int i = 0; i < 8; i++) begin
      chk("s1_bomb",  64'(bombMap), mk(23, -1, -1, -1, -1, -1, -1, -1));
      chk("s1_noblast", 64'(blastMap), 64'd0);
      chk("s1_acc",   64'(accept0), 64'(i == 0));
      chk("s1_free",  64'(freeSlots), 64'd1);
      tick();
    end
    for (int i = 0; i < 4; i++) begin
      chk("s1_blast", 64'(blastMap), mk(13, 22, 23, 24, 33, -1, -1, -1));
      chk("s1_nobomb", 64'(bombMap), 64'd0);
      tick();
    end
    chk("s1_free_end",  64'(freeSlots), 64'd2);
    chk("s1_blast_end", 64'(blastMap), 64'd0);

    // 2: both players at (0,0) same cycle
    reset_dut();
    place0 = 1'b1; p0h = 4'd0; p0v = 4'd0;
    place1 = 1'b1; p1h = 4'd0; p1v = 4'd0;
    tick();
    place0 = 1'b0; place1 = 1'b0;
    tick();
    chk("s2_acc0", 64'({accept0, accept1, reject0, reject1}), 64'b1000);
    chk("s2_bomb", 64'(bombMap), mk(0, -1, -1, -1, -1, -1, -1, -1));
    tick();
    chk("s2_rej1", 64'({accept0, accept1, reject0, reject1}), 64'b0001);
    chk("s2_free", 64'(freeSlots), 64'd1);

    // 3: pool exhaustion plus a re-place while pending
    reset_dut();
    place0 = 1'b1; p0h = 4'd1; p0v = 4'd1;
    place1 = 1'b1; p1h = 4'd2; p1v = 4'd1;
    tick();
    place0 = 1'b0;                      // place1 held: dropped, still pending
    tick();
    place1 = 1'b0;
    chk("s3_c2", 64'({accept0, accept1, reject0, reject1}), 64'b1001);
    tick();
    chk("s3_acc1", 64'({accept0, accept1, reject0, reject1}), 64'b0100);
    chk("s3_bomb", 64'(bombMap), mk(11, 12, -1, -1, -1, -1, -1, -1));
    chk("s3_free0", 64'(freeSlots), 64'd0);
    place0 = 1'b1; p0h = 4'd5; p0v = 4'd0;
    tick();
    place0 = 1'b0;
    tick();
    chk("s3_rej0", 64'({accept0, accept1, reject0, reject1}), 64'b0010);
    chk("s3_bomb2", 64'(bombMap), mk(11, 12, -1, -1, -1, -1, -1, -1));

    // 4: chain reaction A(4,4) -> B(5,4)
    reset_dut();
    place0 = 1'b1; p0h = 4'd4; p0v = 4'd4;
    tick();
    place0 = 1'b0;
    tick();
    tick();
    place1 = 1'b1; p1h = 4'd5; p1v = 4'd4;
    tick();
    place1 = 1'b0;
    tick();
    chk("s4_acc1", 64'(accept1), 64'd1);
    repeat (5) tick();
    chk("s4_bombB", 64'(bombMap), mk(45, -1, -1, -1, -1, -1, -1, -1));
    chk("s4_blastA", 64'(blastMap), mk(34, 43, 44, 45, 54, -1, -1, -1));
    tick();
    chk("s4_chain_bomb", 64'(bombMap), 64'd0);
    chk("s4_chain_blast", 64'(blastMap), mk(34, 35, 43, 44, 45, 46, 54, 55));
    repeat (3) tick();
    chk("s4_blastB", 64'(blastMap), mk(35, 44, 45, 46, 55, -1, -1, -1));
    chk("s4_free1", 64'(freeSlots), 64'd1);
    tick();
    chk("s4_free2", 64'(freeSlots), 64'd2);
    chk("s4_blast0", 64'(blastMap), 64'd0);

    // 5: edge bomb at (9,4), player 1 at (9,5); then place into blast
    reset_dut();
    p1h = 4'd9; p1v = 4'd5;
    place0 = 1'b1; p0h = 4'd9; p0v = 4'd4;
    tick();
    place0 = 1'b0;
    repeat (9) tick();
    chk("s5_blast", 64'(blastMap), mk(39, 48, 49, 59, -1, -1, -1, -1));
    chk("s5_nowrap", 64'(blastMap[50]), 64'd0);
    chk("s5_hit_lag", 64'({hit0, hit1}), 64'd0);
    place1 = 1'b1;
    tick();
    place1 = 1'b0;
    chk("s5_hit", 64'({hit0, hit1}), 64'b11);
    tick();
    chk("s5_acc_blast", 64'(accept1), 64'd1);
    chk("s5_bomb59", 64'(bombMap), mk(59, -1, -1, -1, -1, -1, -1, -1));
    tick();
    chk("s5_chain_bomb", 64'(bombMap), 64'd0);
    chk("s5_chain_blast", 64'(blastMap), mk(39, 48, 49, 58, 59, -1, -1, -1));

    // 6: reset mid-fuse discards bombs and a pending request
    reset_dut();
    place0 = 1'b1; p0h = 4'd2; p0v = 4'd2;
    tick();
    place0 = 1'b0;
    repeat (3) tick();
    chk("s6_bomb", 64'(bombMap), mk(22, -1, -1, -1, -1, -1, -1, -1));
    place1 = 1'b1; p1h = 4'd7; p1v = 4'd0;
    tick();
    place1 = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("s6_bomb0", 64'({bombMap, blastMap}), 64'd0);
    chk("s6_free", 64'(freeSlots), 64'd2);
    chk("s6_acc_rst", 64'(accept1), 64'd0);
    for (int i = 0; i < 2; i++) begin
      tick();
      chk("s6_noacc", 64'({accept0, accept1, reject0, reject1}), 64'd0);
      chk("s6_nobomb", 64'(bombMap), 64'd0);
    end

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
